// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sequencer and datapath.
package cordic_pkg;

  // Default number of micro-rotations per operation.
  localparam int unsigned CORDIC_N_ITER_DEF = 16;

  // Sequencer states; encodings fixed to match the legacy register values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_HOLD = 2'd3
  } cordic_state_e;

  // Width of the iteration index (shift amount / atan table address).
  function automatic int unsigned cordic_idx_w(input int unsigned n_iter);
    return (n_iter < 2) ? 1 : $clog2(n_iter);
  endfunction

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration counter: up counter with synchronous clear and terminal flag.
module cordic_iter_cnt #(
  parameter int unsigned N_ITER = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] cnt,
  output logic             term
);

  // Count up when enabled; clear takes priority and never wraps in use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == IDX_W'(N_ITER - 1));

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Iteration sequencer for the iterative CORDIC datapath: load, N_ITER
// micro-rotations, then hold the result-valid flag until acknowledged.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned N_ITER = CORDIC_N_ITER_DEF,
  parameter int unsigned IDX_W  = cordic_idx_w(N_ITER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             res_ack,
  output logic             busy,
  output logic             load,
  output logic             iter_en,
  output logic [IDX_W-1:0] iter_idx,
  output logic             done
);

  cordic_state_e    state;
  cordic_state_e    state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             cnt_term;
  logic             cnt_clr;
  logic             cnt_en;

  // Counter is cleared on entry to ITER (via LOAD), on leaving ITER and on abort.
  assign cnt_clr = abort || (state == ST_LOAD) || ((state == ST_ITER) && cnt_term);
  assign cnt_en  = (state == ST_ITER);

  cordic_iter_cnt #(
    .N_ITER (N_ITER),
    .IDX_W  (IDX_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .term (cnt_term)
  );

  // Next-state logic; abort overrides every other request.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_LOAD;
        ST_LOAD: state_nxt = ST_ITER;
        ST_ITER: if (cnt_term) state_nxt = ST_HOLD;
        ST_HOLD: begin
          if (res_ack && start) state_nxt = ST_LOAD;
          else if (res_ack)     state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Moore output decode from registered state and counter.
  always_comb begin
    busy     = (state == ST_LOAD) || (state == ST_ITER);
    load     = (state == ST_LOAD);
    iter_en  = (state == ST_ITER);
    iter_idx = (state == ST_ITER) ? cnt : '0;
    done     = (state == ST_HOLD);
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed self-checking bench for cordic_seq_ctrl with N_ITER = 16.
module tb_cordic_seq_ctrl;

  localparam int unsigned NI = 16;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       res_ack;
  logic       busy;
  logic       load;
  logic       iter_en;
  logic [3:0] iter_idx;
  logic       done;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  cordic_seq_ctrl #(
    .N_ITER (NI),
    .IDX_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .res_ack  (res_ack),
    .busy     (busy),
    .load     (load),
    .iter_en  (iter_en),
    .iter_idx (iter_idx),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare packed outputs {busy,load,iter_en,done,iter_idx}.
  task automatic chk(input string tag, input logic eb, input logic el,
                     input logic ei, input logic ed, input logic [3:0] ex);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {busy, load, iter_en, done, iter_idx};
    exp = {eb, el, ei, ed, ex};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed b/l/i/d/idx=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // Pulse start for one edge and check the LOAD cycle.
  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk(tag, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  // Walk the full ITER phase checking the index sequence, then HOLD.
  task automatic run_iters(input string tag);
    for (int i = 0; i < int'(NI); i++) begin
      step();
      chk(tag, 1'b1, 1'b0, 1'b1, 1'b0, 4'(i));
    end
    step();
    chk({tag, "_done"}, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    res_ack = 1'b0;

    // Reset phase
    #2;
    chk_idle("reset_active");
    #8;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("post_reset_idle");
    end

    // Single operation, with start/res_ack pulsed mid-ITER (must be ignored)
    do_start("single_load");
    for (int i = 0; i < int'(NI); i++) begin
      if (i == 4) begin
        start   = 1'b1;
        res_ack = 1'b1;
      end
      step();
      start   = 1'b0;
      res_ack = 1'b0;
      chk("single_iter", 1'b1, 1'b0, 1'b1, 1'b0, 4'(i));
    end
    step();
    chk("single_done_rise", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    // start without res_ack in HOLD is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hold_start_ignored", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    chk("hold_held", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    chk_idle("ack_to_idle");

    // res_ack in IDLE ignored; abort beats start in IDLE
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    chk_idle("idle_ack_ignored");
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk_idle("idle_abort_start");
    step();
    chk_idle("idle_abort_start_2");

    // Back-to-back operation
    do_start("b2b_load1");
    run_iters("b2b_op1");
    start   = 1'b1;
    res_ack = 1'b1;
    step();
    start   = 1'b0;
    res_ack = 1'b0;
    chk("b2b_load2", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    run_iters("b2b_op2");
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    chk_idle("b2b_ack");

    // Abort at iter_idx = 7
    do_start("abort_load");
    for (int i = 0; i <= 7; i++) begin
      step();
      chk("abort_iter", 1'b1, 1'b0, 1'b1, 1'b0, 4'(i));
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort_next");
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle("abort_no_done");
    end
    do_start("post_abort_load");
    run_iters("post_abort_op");
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    chk_idle("post_abort_ack");

    // Asynchronous reset mid-ITER at iter_idx = 5
    do_start("areset_load");
    for (int i = 0; i <= 5; i++) begin
      step();
      chk("areset_iter", 1'b1, 1'b0, 1'b1, 1'b0, 4'(i));
    end
    #2;
    rst = 1'b0;
    #1;
    chk_idle("areset_immediate");
    #2;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("areset_release_idle");
    end
    do_start("post_areset_load");
    run_iters("post_areset_op");
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    chk_idle("post_areset_ack");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Iteration sequencer for the iterative CORDIC datapath. Accepts a start request, loads operands, steps through `N_ITER` micro-rotations, and holds a result-valid flag until the consumer acknowledges it. Per cycle it drives:
- the datapath load strobe,
- the rotate enable,
- the iteration index, which is both the shift amount and the arctangent-table address.

It sits between the host/request logic and the CORDIC x/y/z register datapath.

## Interface
- `N_ITER`, default 16: number of micro-rotations per operation; legal range ≥ 2.
- `IDX_W`, default `$clog2(N_ITER)`: width of the iteration index.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset asserted).
- `start`  in  1  operation request; honoured only in IDLE, or in HOLD together with `res_ack`.
- `abort`  in  1  synchronous cancel; highest priority after reset.
- `res_ack`  in  1  consumer has taken the result; honoured only in HOLD.
- `busy`  out  1  high in LOAD and ITER.
- `load`  out  1  one-cycle strobe: datapath captures operands.
- `iter_en`  out  1  datapath performs one micro-rotation this cycle.
- `iter_idx`  out  `IDX_W`  current iteration number (0..`N_ITER`-1); 0 outside ITER.
- `done`  out  1  result valid; a level held through HOLD.

## Operation
- FSM states are IDLE, LOAD, ITER, HOLD. All outputs are decoded from registered state and the counter (Moore), so they are glitch-free.
- **IDLE**: all outputs 0.
  - `start`=1 → LOAD.
- **LOAD**: `load`=1 and `busy`=1; the counter is cleared to 0.
  - Always → ITER.
- **ITER**: `iter_en`=1, `busy`=1, `iter_idx`=counter.
  - Counter increments every cycle.
  - When counter = `N_ITER`-1 → HOLD, and the counter clears.
- **HOLD**: `done`=1.
  - `res_ack`=1 and `start`=1 → LOAD (back-to-back operation).
  - `res_ack`=1 alone → IDLE.
  - `start` without `res_ack` is ignored.
- **abort**=1 in any state → IDLE on the next edge and the counter clears. `done` is never asserted for an aborted operation. `abort` overrides `start` and `res_ack` in the same cycle.
- `res_ack` outside HOLD is ignored. `start` in LOAD/ITER is ignored; no queuing.
- The counter never wraps. Reaching its terminal value forces the transition to HOLD.
- Reset values: state IDLE, counter 0, and all outputs 0 (`busy`, `load`, `iter_en`, `iter_idx`, `done`).

## Timing
- `start` is sampled at edge E0 in IDLE.
  - `load` is high for the cycle E0→E1.
  - `iter_en` is high for E1→E(N_ITER+1), with `iter_idx` = 0,1,…,`N_ITER`-1.
  - `done` rises at E(N_ITER+1).
- Start-to-done latency is `N_ITER`+1 cycles.
- With `start` and `res_ack` held high, operations repeat every `N_ITER`+2 cycles.
- `done` falls on the edge that samples `res_ack`=1.
- Asserting `rst` clears everything immediately, without waiting for a clock edge, including mid-ITER. After `rst` is released, the block waits in IDLE for a fresh `start`.
- Abort latency is one edge. The cycle after the abort edge shows `busy`=`iter_en`=`load`=0 and `iter_idx`=0.

## Structure
- `cordic_pkg` holds:
  - the state enum typedef (IDLE/LOAD/ITER/HOLD);
  - the default `N_ITER` constant;
  - the index-width helper function, which the datapath also uses.
- Sub-module `cordic_iter_cnt` is an `IDX_W`-bit up counter with:
  - async active-low `rst`;
  - synchronous `clr`;
  - `en`;
  - a `term` output flag that is high when the count equals `N_ITER`-1.
- The FSM and output decode live in `cordic_seq_ctrl`.

## Test plan
Bench uses `N_ITER`=16 and a 10 ns clock.
- **Reset**: `rst`=0 for 10 ns, then 1, with `start`=0 → all outputs 0 and the block stays in IDLE for 5 cycles.
- **Single operation**: pulse `start` for one cycle → `load` for 1 cycle; `iter_en` for 16 cycles with `iter_idx` 0..15 in order; `done`=1 from cycle 17 and held until `res_ack`, then 0 on the next edge.
- **Back-to-back**: in HOLD, drive `start`=`res_ack`=1 together → `done` drops and `load`=1 in the same next cycle. Second `done` arrives 17 cycles later.
- **Abort**: assert `abort` when `iter_idx`=7 → next cycle `busy`=`iter_en`=0, `iter_idx`=0, and `done` never asserts. A new `start` then runs normally.
- **Asynchronous reset mid-ITER**: drop `rst` between edges at `iter_idx`=5 → all outputs 0 before the next clock edge. After release, no activity until `start`.
- **Ignored inputs**: `start` during ITER and `res_ack` during ITER or IDLE → no change in sequence or counts. `abort` together with `start` in IDLE → stays in IDLE.
